// File: rtl/tff_chain.sv
// tff_chain: multi-lane cascade of T flip-flops, selectable level-cascade or binary-counter mode.
// Define TFF_CHAIN_EDGE_CNT_EN to add a saturating per-lane count of q rising edges (edge_cnt).
module tff_chain #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned LANES  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     mode,
    input  logic [LANES-1:0]         data,
    output logic [LANES*STAGES-1:0]  taps,
    output logic [LANES-1:0]         q,
`ifdef TFF_CHAIN_EDGE_CNT_EN
    output logic [LANES*CNT_W-1:0]   edge_cnt,
`endif
    output logic [LANES-1:0]         wrap
);

    localparam int unsigned TW = LANES * STAGES;

    if (STAGES < 1 || LANES < 1 || CNT_W < 1) begin : g_bad_params
        $error("tff_chain: STAGES, LANES and CNT_W must all be >= 1");
    end

    logic [TW-1:0]     stage_q, stage_d;
    logic [LANES-1:0]  wrap_q, wrap_d;
    logic [STAGES-1:0] cur;
    logic [STAGES-1:0] tgl;
    logic              carry;

    // Toggle enables: mode 0 chains on the previous stage, mode 1 on the AND of all lower stages.
    always_comb begin
        stage_d = stage_q;
        wrap_d  = '0;
        cur     = '0;
        tgl     = '0;
        carry   = 1'b0;
        if (clr) begin
            stage_d = '0;
        end else if (en) begin
            for (int l = 0; l < int'(LANES); l++) begin
                cur    = stage_q[l*STAGES +: STAGES];
                tgl    = '0;
                carry  = data[l];
                tgl[0] = data[l];
                for (int k = 1; k < int'(STAGES); k++) begin
                    carry  = carry & cur[k-1];
                    tgl[k] = mode ? carry : cur[k-1];
                end
                stage_d[l*STAGES +: STAGES] = cur ^ tgl;
                wrap_d[l] = mode & data[l] & (&cur);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            wrap_q  <= '0;
        end else begin
            stage_q <= stage_d;
            wrap_q  <= wrap_d;
        end
    end

    assign taps = stage_q;
    assign wrap = wrap_q;

    for (genvar l = 0; l < LANES; l++) begin : g_q
        assign q[l] = stage_q[l*STAGES + STAGES - 1];
    end

`ifdef TFF_CHAIN_EDGE_CNT_EN
    logic [LANES*CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_cur;

    // Count q rising edges per lane, saturating at all-ones.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_cur = '0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            for (int l = 0; l < int'(LANES); l++) begin
                cnt_cur = cnt_q[l*CNT_W +: CNT_W];
                if (stage_d[l*STAGES + STAGES - 1] && !stage_q[l*STAGES + STAGES - 1]
                    && !(&cnt_cur)) begin
                    cnt_d[l*CNT_W +: CNT_W] = cnt_cur + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign edge_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tff_chain.sv
// Self-checking bench for tff_chain: three instances (4x2, 2x1, 1x1) sharing control inputs.
// Table vectors and model-driven random stimulus flow through an expectation queue.
module tb_tff_chain;

    localparam int unsigned CW = 4;

    logic       clk = 1'b0;
    logic       rst, en, clr, mode;
    logic [1:0] data_a;
    logic [0:0] data_b, data_c;
    logic [7:0] taps_a;
    logic [1:0] q_a, wrap_a;
    logic [1:0] taps_b;
    logic [0:0] q_b, wrap_b;
    logic [0:0] taps_c, q_c, wrap_c;
`ifdef TFF_CHAIN_EDGE_CNT_EN
    logic [2*CW-1:0] ec_a;
    logic [CW-1:0]   ec_b;
    logic [CW-1:0]   ec_c;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tff_chain #(.STAGES(4), .LANES(2), .CNT_W(CW)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .data(data_a),
        .taps(taps_a), .q(q_a),
`ifdef TFF_CHAIN_EDGE_CNT_EN
        .edge_cnt(ec_a),
`endif
        .wrap(wrap_a));

    tff_chain #(.STAGES(2), .LANES(1), .CNT_W(CW)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .data(data_b),
        .taps(taps_b), .q(q_b),
`ifdef TFF_CHAIN_EDGE_CNT_EN
        .edge_cnt(ec_b),
`endif
        .wrap(wrap_b));

    tff_chain #(.STAGES(1), .LANES(1), .CNT_W(CW)) u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .data(data_c),
        .taps(taps_c), .q(q_c),
`ifdef TFF_CHAIN_EDGE_CNT_EN
        .edge_cnt(ec_c),
`endif
        .wrap(wrap_c));

    typedef struct {
        string      name;
        logic       en, clr, mode;
        logic [1:0] da;
        logic       db;
        logic [7:0] ta;
        logic [1:0] wa;
        logic [1:0] tb;
        logic       chk_a, chk_b;
    } vec_t;

    vec_t sb_q[$];

    function automatic vec_t mk(string nm, logic e, logic c, logic m, logic [1:0] da, logic db,
                                logic [7:0] ta, logic [1:0] wa, logic [1:0] tb,
                                logic ca, logic cb);
        vec_t v;
        v.name = nm; v.en = e; v.clr = c; v.mode = m; v.da = da; v.db = db;
        v.ta = ta; v.wa = wa; v.tb = tb; v.chk_a = ca; v.chk_b = cb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, then compare after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        en = v.en; clr = v.clr; mode = v.mode; data_a = v.da; data_b = v.db;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (e.chk_a) begin
            chk({e.name, ".taps_a"}, 32'(taps_a), 32'(e.ta));
            chk({e.name, ".q_a"},    32'(q_a),    32'({e.ta[7], e.ta[3]}));
            chk({e.name, ".wrap_a"}, 32'(wrap_a), 32'(e.wa));
        end
        if (e.chk_b) begin
            chk({e.name, ".taps_b"}, 32'(taps_b), 32'(e.tb));
            chk({e.name, ".q_b"},    32'(q_b),    32'(e.tb[1]));
            chk({e.name, ".wrap_b"}, 32'(wrap_b), 32'd0);
        end
    endtask

    // Independent lane model: mode 1 adds, mode 0 xors with the shifted-in predecessors.
    function automatic logic [3:0] nxt4(logic [3:0] s, logic d, logic m);
        return m ? s + 4'(d) : s ^ {s[2:0], d};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       t0[7];
        vec_t       t1[5];
        vec_t       t2[4];
        logic [3:0] ms[2];
        logic [1:0] mw;
        logic [7:0] ta;
        logic       re, rc, rm;
        logic [1:0] rd;

        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;

        t0[0] = mk("m0_e1", 1, 0, 0, 2'b00, 1, 8'h00, 2'b00, 2'b01, 1, 1);
        t0[1] = mk("m0_e2", 1, 0, 0, 2'b00, 1, 8'h00, 2'b00, 2'b10, 1, 1);
        t0[2] = mk("m0_e3", 1, 0, 0, 2'b00, 1, 8'h00, 2'b00, 2'b11, 1, 1);
        t0[3] = mk("m0_e4", 1, 0, 0, 2'b00, 1, 8'h00, 2'b00, 2'b00, 1, 1);
        t0[4] = mk("m0_e5", 1, 0, 0, 2'b00, 1, 8'h00, 2'b00, 2'b01, 1, 1);
        t0[5] = mk("m0_e6", 1, 0, 0, 2'b00, 1, 8'h00, 2'b00, 2'b10, 1, 1);
        t0[6] = mk("clr_en0", 0, 1, 1, 2'b11, 1, 8'h00, 2'b00, 2'b00, 1, 1);

        t1[0] = mk("hold1", 0, 0, 1, 2'b11, 0, 8'h44, 2'b00, 2'b00, 1, 0);
        t1[1] = mk("hold2", 0, 0, 1, 2'b11, 0, 8'h44, 2'b00, 2'b00, 1, 0);
        t1[2] = mk("hold3", 0, 0, 1, 2'b11, 0, 8'h44, 2'b00, 2'b00, 1, 0);
        t1[3] = mk("clr_en1", 1, 1, 1, 2'b11, 1, 8'h00, 2'b00, 2'b00, 1, 1);
        t1[4] = mk("post_clr", 1, 0, 1, 2'b00, 0, 8'h00, 2'b00, 2'b00, 1, 1);

        t2[0] = mk("mchg1", 1, 0, 0, 2'b00, 0, 8'h0F, 2'b00, 2'b00, 1, 0);
        t2[1] = mk("mchg2", 1, 0, 0, 2'b00, 0, 8'h01, 2'b00, 2'b00, 1, 0);
        t2[2] = mk("mchg3", 1, 0, 1, 2'b01, 0, 8'h02, 2'b00, 2'b00, 1, 0);
        t2[3] = mk("mchg4", 1, 0, 0, 2'b10, 0, 8'h16, 2'b00, 2'b00, 1, 0);

        #12;
        chk("rst.taps_a", 32'(taps_a), 32'd0);
        chk("rst.q_a",    32'(q_a),    32'd0);
        chk("rst.wrap_a", 32'(wrap_a), 32'd0);
        chk("rst.taps_b", 32'(taps_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) apply(t0[i]);

        // Binary count on both lanes, through the wrap and one edge beyond.
        for (int i = 1; i <= 20; i++) begin
            apply(mk($sformatf("cnt%0d", i), 1, 0, 1, 2'b11, 0,
                     {4'(i), 4'(i)}, (i == 16) ? 2'b11 : 2'b00, 2'b00, 1, 1));
        end
        for (int i = 0; i < 5; i++) apply(t1[i]);

        for (int i = 1; i <= 5; i++) begin
            apply(mk($sformatf("iso%0d", i), 1, 0, 1, 2'b01, 0,
                     {4'h0, 4'(i)}, 2'b00, 2'b00, 1, 0));
        end
        for (int i = 0; i < 4; i++) apply(t2[i]);

        // Model-driven random traffic from a cleared state.
        apply(mk("rnd_clr", 1, 1, 0, 2'b00, 0, 8'h00, 2'b00, 2'b00, 1, 1));
        ms[0] = 4'h0; ms[1] = 4'h0;
        for (int i = 0; i < 80; i++) begin
            re = ($urandom_range(0, 7) != 0);
            rc = ($urandom_range(0, 19) == 0);
            rm = ($urandom_range(0, 3) != 0);
            rd = 2'($urandom);
            mw = 2'b00;
            for (int l = 0; l < 2; l++) begin
                if (rc) begin
                    ms[l] = 4'h0;
                end else if (re) begin
                    mw[l] = rm & rd[l] & (ms[l] == 4'hF);
                    ms[l] = nxt4(ms[l], rd[l], rm);
                end
            end
            ta = {ms[1], ms[0]};
            apply(mk($sformatf("rnd%0d", i), re, rc, rm, rd, 0, ta, mw, 2'b00, 1, 0));
        end

        // Asynchronous reset between edges, held across an edge.
        apply(mk("ar_clr", 1, 1, 1, 2'b11, 0, 8'h00, 2'b00, 2'b00, 1, 0));
        for (int i = 1; i <= 3; i++) begin
            apply(mk($sformatf("ar_cnt%0d", i), 1, 0, 1, 2'b11, 0,
                     {4'(i), 4'(i)}, 2'b00, 2'b00, 1, 0));
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.taps_a", 32'(taps_a), 32'd0);
        chk("arst.q_a",    32'(q_a),    32'd0);
        chk("arst.wrap_a", 32'(wrap_a), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold.taps_a", 32'(taps_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-stage lane: q toggles every edge, rising edge every second edge.
        @(negedge clk);
        en = 1'b1; clr = 1'b1; mode = 1'b0; data_a = '0; data_b = '0; data_c = 1'b0;
        @(negedge clk);
        clr = 1'b0; data_c = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("c_q_e%0d", e), 32'(q_c), 32'(e % 2));
`ifdef TFF_CHAIN_EDGE_CNT_EN
            chk($sformatf("c_ec_e%0d", e), 32'(ec_c), 32'((e + 1) / 2 > 15 ? 15 : (e + 1) / 2));
`endif
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("c_clr.q", 32'(q_c), 32'd0);
`ifdef TFF_CHAIN_EDGE_CNT_EN
        chk("c_clr.ec", 32'(ec_c), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tff_chain.md
Name: tff_chain

Overview:
- Parametrised multi-lane cascade of T flip-flops. Each lane is an independent chain of STAGES toggle registers.
- Run-time mode selects between two behaviours:
  - Level cascade: each stage toggles while the previous stage's registered output is 1.
  - Synchronous binary counter of data-high cycles.
- Used as a clock-enable divider, toggle-pattern generator and event counter inside small control blocks.

Parameters:
- STAGES, 4, T flip-flops per lane (>=1); stage 0 is driven by data.
- LANES, 2, number of independent chains (>=1).
- CNT_W, 8, width of per-lane edge counter (used only with optional feature).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global advance enable; 0 freezes all state.
- clr  input  1  synchronous clear of all stages, wrap and counters.
- mode  input  1  0 = level cascade, 1 = binary counter.
- data  input  LANES  per-lane toggle request into stage 0.
- taps  output  LANES*STAGES  all stage registers; lane l stage k at bit l*STAGES+k.
- q  output  LANES  last stage of each lane (taps bit l*STAGES+STAGES-1).
- wrap  output  LANES  registered one-cycle pulse on counter wrap (mode 1 only).

Behaviour:
- Reset: while rst=1, all stage registers, q, taps and wrap = 0, asynchronously. Release takes effect at the next clk edge. Reset mid-operation discards all state immediately.
- Priority per edge: rst > clr > en=0 (hold) > normal update.
- clr=1: all stages and wrap go to 0 on that edge, regardless of en, data and mode.
- en=0 and clr=0: everything holds. Wrap is forced to 0 for that cycle.
- Mode 0 (level cascade), per lane l:
  - s[0] toggles when data[l]=1.
  - s[k] (k>=1) toggles when the pre-edge value of s[k-1] is 1.
  - All stages update in parallel from pre-edge values, so a data change reaches stage k after k+1 edges.
  - With STAGES=2 this exactly matches the existing two-stage T-FF pair.
- Mode 1 (counter), per lane l:
  - s[k] toggles when data[l]=1 and s[0..k-1] are all 1 (pre-edge).
  - Lane value = unsigned count of data-high enabled cycles, modulo 2^STAGES, with s[0] as LSB.
  - wrap[l] = 1 for exactly the cycle after an edge in which the lane went from all-ones to all-zeros. Otherwise 0. Always 0 in mode 0.
- Mode change: the new mode applies at the next edge, using the current stage values as the starting state. No stage is cleared on a mode change.
- Lanes are fully independent; no cross-lane logic.
- No combinational path from any input to any output: q, taps and wrap are all direct register outputs.

Optional Feature:
- Macro TFF_CHAIN_EDGE_CNT_EN.
- Defined:
  - Adds output edge_cnt, LANES*CNT_W, lane l at bits l*CNT_W +: CNT_W.
  - Each counter increments by 1 on every edge where q[l] goes 0->1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared by rst (async) and clr. Holds when en=0.
- Undefined: edge_cnt port and all its logic are absent. All other behaviour is identical.

Test Plan:
- Async reset: run mode 1 to a nonzero count, assert rst between edges -> taps, q and wrap read 0 before the next edge, and stay 0 until release.
- Mode 0, STAGES=2, LANES=1, data=1 from reset release -> (s0,s1) after edges 1..6 = (1,0),(0,1),(1,1),(0,0),(1,0),(0,1).
- Mode 1, STAGES=4, data=1, en=1 -> taps count 1,2,...,15,0. wrap=1 only in the cycle after edge 16, and 0 in all others.
- Priority: mid-count assert en=0 for 3 cycles -> value frozen, wrap 0. Then clr=1 with en=1, data=1 -> all stages 0 after that edge.
- Lane isolation, LANES=2, mode 1: data=2'b01 for 5 edges -> lane0 = 5, lane1 = 0, wrap = 2'b00.
- With TFF_CHAIN_EDGE_CNT_EN, CNT_W=4, mode 0, STAGES=1, data=1 -> edge_cnt counts 1..15 over 30 edges, then holds 15; clr returns it to 0.
